// File: rtl/jt49_env_if.sv
// Envelope generator control/status bundle: divider tick, shape, restart strobe
// and the resulting envelope level.
`timescale 1ns/1ps
interface jt49_env_if;
  logic       cen;
  logic       env_div;
  logic [3:0] shape;
  logic       restart;
  logic [4:0] env;
  logic       env_hold;

  modport master (
    output cen, env_div, shape, restart,
    input  env, env_hold
  );

  modport slave (
    input  cen, env_div, shape, restart,
    output env, env_hold
  );
endinterface

// File: rtl/jt49_env.sv
// AY-3-8910 style envelope generator: 32-step ramp driven by the envelope divider,
// shaped by {CONT,ATT,ALT,HOLD}, with a registered 5-bit level output.
`timescale 1ns/1ps
module jt49_env #(
  parameter bit STEP_BOTH = 1'b0
) (
  input logic       clk,
  input logic       rst,
  jt49_env_if.slave bus
);

  logic [4:0] cnt_reg, cnt_next;
  logic       att_reg, att_next;
  logic       hold_reg, hold_next;
  logic       last_div_reg, last_div_next;
  logic [4:0] env_reg, env_next;
  logic       adv;
  logic       shape_cont, shape_att, shape_alt, shape_hold;

  assign shape_cont = bus.shape[3];
  assign shape_att  = bus.shape[2];
  assign shape_alt  = bus.shape[1];
  assign shape_hold = bus.shape[0];

  generate
    if (STEP_BOTH) begin : g_both_edges
      assign adv = bus.cen & (bus.env_div ^ last_div_reg);
    end else begin : g_rise_edge
      assign adv = bus.cen & bus.env_div & ~last_div_reg;
    end
  endgenerate

  always_comb begin
    cnt_next      = cnt_reg;
    att_next      = att_reg;
    hold_next     = hold_reg;
    env_next      = env_reg;
    last_div_next = bus.cen ? bus.env_div : last_div_reg;

    if (bus.restart) begin
      cnt_next  = 5'd0;
      att_next  = shape_att;
      hold_next = 1'b0;
      env_next  = shape_att ? 5'd0 : 5'd31;
    end else if (adv && !hold_reg) begin
      if (cnt_reg != 5'd31) begin
        cnt_next = cnt_reg + 5'd1;
        env_next = att_reg ? cnt_next : ~cnt_next;
      end else if (!shape_cont) begin
        // One-shot shapes always end silent, whatever ATT/ALT say
        hold_next = 1'b1;
        att_next  = 1'b0;
        env_next  = 5'd0;
      end else if (shape_hold) begin
        hold_next = 1'b1;
        att_next  = att_reg ^ shape_alt;
        env_next  = att_next ? 5'd31 : 5'd0;
      end else begin
        cnt_next = 5'd0;
        att_next = att_reg ^ shape_alt;
        env_next = att_next ? 5'd0 : 5'd31;
      end
    end
  end

  // Reset leaves the output silent and frozen until software writes a shape
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg      <= 5'd0;
      att_reg      <= 1'b0;
      hold_reg     <= 1'b1;
      last_div_reg <= 1'b0;
      env_reg      <= 5'd0;
    end else begin
      cnt_reg      <= cnt_next;
      att_reg      <= att_next;
      hold_reg     <= hold_next;
      last_div_reg <= last_div_next;
      env_reg      <= env_next;
    end
  end

  assign bus.env      = env_reg;
  assign bus.env_hold = hold_reg;

endmodule
